// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit frame sequencer: FSM states, line-select codes, parity types.
// Pure declarations; no logic, no latency.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEL_START = 2'd0,
    SEL_STOP  = 2'd1,
    SEL_DATA  = 2'd2,
    SEL_PAR   = 2'd3
  } sel_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity of the outgoing byte; par_typ selects even (0) or odd (1).
// Zero latency, no handshake.
module uart_tx_parity #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^p_data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start/data/parity/stop muxing, serializer enable, busy, watchdog abort.
// Frame starts the cycle after Data_valid is taken in IDLE/STOP; UART_TX_TWO_STOP_EN adds a second stop bit.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WDOG_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_en,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_err
);

  localparam int WDOG_W = $clog2(DATA_WIDTH + WDOG_SLACK) + 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(DATA_WIDTH + WDOG_SLACK - 1);

  state_t            state_q, state_d;
  sel_t              sel;
  logic              par_q, par_en_q;
  logic              tx_err_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              accept, abort;
  logic              par_bit;

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .p_data (P_Data),
    .par_typ(PAR_TYP),
    .par_bit(par_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      wdog_q   <= '0;
      tx_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_err_q <= abort;
      if (accept) begin
        par_q    <= par_bit;
        par_en_q <= PAR_EN;
      end
      if (state_q == START) begin
        wdog_q <= '0;
      end else if (state_q == DATA) begin
        wdog_q <= wdog_q + WDOG_W'(1);
      end
    end
  end

  // The last stop cycle is the only busy cycle that may take a new request.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Data_valid) begin
          state_d = START;
          accept  = 1'b1;
        end
      end
      START: state_d = DATA;
      DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end else if (wdog_q == WDOG_MAX) begin
          state_d = STOP;
          abort   = 1'b1;
        end
      end
      PARITY: state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
      STOP: state_d = STOP2;
      STOP2: begin
        if (Data_valid) begin
          state_d = START;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`else
      STOP: begin
        if (Data_valid) begin
          state_d = START;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel    = SEL_STOP;
    ser_en = 1'b0;
    busy   = 1'b0;
    case (state_q)
      START: begin
        sel  = SEL_START;
        busy = 1'b1;
      end
      DATA: begin
        sel    = SEL_DATA;
        ser_en = 1'b1;
        busy   = 1'b1;
      end
      PARITY: begin
        sel  = SEL_PAR;
        busy = 1'b1;
      end
      STOP: busy = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
      STOP2: busy = 1'b1;
`endif
      default: begin
        sel    = SEL_STOP;
        ser_en = 1'b0;
        busy   = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    case (sel)
      SEL_START: tx_out = 1'b0;
      SEL_STOP:  tx_out = 1'b1;
      SEL_DATA:  tx_out = ser_data;
      SEL_PAR:   tx_out = par_q;
      default:   tx_out = 1'b1;
    endcase
  end

  assign tx_err = tx_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: serializer model, per-frame expected-output queue, literal frame checks.
module tb_uart_tx_ctrl;

  localparam int DW    = 8;
  localparam int SLACK = 2;
`ifdef UART_TX_TWO_STOP_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif
  localparam int L_P = 11 + XS;
  localparam int L_N = 10 + XS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] P_Data = '0;
  logic          Data_valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          ser_done;
  logic          ser_data;
  logic          ser_en;
  logic          tx_out;
  logic          busy;
  logic          tx_err;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .WDOG_SLACK(SLACK)) dut (
    .clk       (clk),
    .rst       (rst),
    .P_Data    (P_Data),
    .Data_valid(Data_valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .ser_done  (ser_done),
    .ser_data  (ser_data),
    .ser_en    (ser_en),
    .tx_out    (tx_out),
    .busy      (busy),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  // Serializer model: LSB first while enabled, done on the last data bit.
  logic [DW-1:0] ser_byte = '0;
  logic [4:0]    ser_cnt;
  logic          no_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst || !ser_en) ser_cnt <= '0;
    else                ser_cnt <= ser_cnt + 5'd1;
  end
  assign ser_data = (ser_cnt < DW) ? ser_byte[ser_cnt[2:0]] : 1'b1;
  assign ser_done = ser_en && !no_done && (ser_cnt == DW - 1);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected {tx_out, busy, ser_en, tx_err} per cycle; empty queue means idle line.
  logic [3:0] exp_q[$];
  int busy_cnt, en_cnt, err_cnt, busy_run, busy_max, tx_idx;
  logic tx_log[32];

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1000;
      check("cycle_outputs", {28'd0, tx_out, busy, ser_en, tx_err}, {28'd0, e});
      busy_cnt += int'(busy);
      en_cnt   += int'(ser_en);
      err_cnt  += int'(tx_err);
      if (busy) begin
        busy_run++;
        if (busy_run > busy_max) busy_max = busy_run;
        if (tx_idx < 32) tx_log[tx_idx] = tx_out;
        tx_idx++;
      end else begin
        busy_run = 0;
      end
    end
  end

  task automatic clr_stats();
    busy_cnt = 0; en_cnt = 0; err_cnt = 0; busy_run = 0; busy_max = 0; tx_idx = 0;
  endtask

  function automatic logic [10:0] log11();
    logic [10:0] r;
    for (int i = 0; i < 11; i++) r[10-i] = tx_log[i];
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drive a request now (just after a compare) and queue the frame it must produce.
  task automatic start_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic ab);
    int n;
    P_Data = d; PAR_EN = pe; PAR_TYP = pt; Data_valid = 1'b1;
    ser_byte = d; no_done = ab;
    exp_q.push_back(4'b0100);
    n = ab ? DW + SLACK : DW;
    for (int i = 0; i < n; i++) exp_q.push_back({(i < DW) ? d[i] : 1'b1, 3'b110});
    if (pe && !ab) exp_q.push_back({(^d) ^ pt, 3'b100});
    exp_q.push_back({3'b110, ab});
    if (XS == 1) exp_q.push_back(4'b1100);
    wait_cyc(1);
    Data_valid = 1'b0;
  endtask

  initial begin
    clr_stats();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_state", {28'd0, tx_out, busy, ser_en, tx_err}, 32'h8);
    rst = 1'b0;
    wait_cyc(2);

    // Basic frame 0xA5, even parity.
    clr_stats();
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_cyc(L_P - 1);
    check("a5_tx_bits", {21'd0, log11()}, {21'd0, 11'b01010010101});
    check("a5_busy_len", busy_cnt, L_P);
    check("a5_ser_en_len", en_cnt, 8);
    wait_cyc(2);

    // Odd parity of 0x07 gives 0.
    clr_stats();
    start_frame(8'h07, 1'b1, 1'b1, 1'b0);
    wait_cyc(L_P - 1);
    check("odd07_tx_bits", {21'd0, log11()}, {21'd0, 11'b01110000001});
    wait_cyc(2);

    // No parity cycle.
    clr_stats();
    start_frame(8'h07, 1'b0, 1'b1, 1'b0);
    wait_cyc(L_N - 1);
    check("nopar_busy_len", busy_cnt, L_N);
    wait_cyc(2);

    // Back-to-back: second request during the final stop cycle.
    clr_stats();
    start_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_cyc(L_P - 1);
    start_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_cyc(L_P - 1);
    check("b2b_busy_run", busy_max, 2 * L_P);
    wait_cyc(2);

    // Watchdog: serializer never completes.
    clr_stats();
    start_frame(8'h55, 1'b1, 1'b0, 1'b1);
    wait_cyc(12 + XS - 1);
    check("wdog_err_pulses", err_cnt, 1);
    check("wdog_data_cycles", en_cnt, 10);
    check("wdog_busy_len", busy_cnt, 12 + XS);
    wait_cyc(2);
    check("wdog_idle_after", busy_run, 0);

    // Reset during the 4th DATA cycle.
    clr_stats();
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_cyc(4);
    rst = 1'b1;
    #1;
    check("midrst_tx_out", {31'd0, tx_out}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ser_en", {31'd0, ser_en}, 32'd0);
    exp_q.delete();
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    clr_stats();
    start_frame(8'h81, 1'b1, 1'b0, 1'b0);
    wait_cyc(L_P - 1);
    check("post_rst_81_bits", {21'd0, log11()}, {21'd0, 11'b01000000101});
    check("post_rst_81_len", busy_cnt, L_P);
    wait_cyc(2);

    // Request during DATA is ignored.
    clr_stats();
    start_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_cyc(3);
    P_Data = 8'hFF; PAR_EN = 1'b0; Data_valid = 1'b1;
    wait_cyc(1);
    Data_valid = 1'b0;
    wait_cyc(L_P - 5);
    check("ignored_req_len", busy_cnt, L_P);
    wait_cyc(3);
    check("ignored_req_idle", busy_run, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a parallel byte handshake and drives the serializer enable, then muxes start, data, parity and stop bits onto the TX line.
- Computes and holds the parity bit and reports busy.
- Detects a missing serializer completion with a watchdog.

Parameters:
- DATA_WIDTH, 8: data bits per frame; bounds the watchdog.
- WDOG_SLACK, 2: extra DATA cycles tolerated beyond DATA_WIDTH before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, active-high, asynchronous. One clock domain only.
- P_Data  in  DATA_WIDTH  byte to transmit. Used only for parity; the serializer latches the data itself.
- Data_valid  in  1  request; accepted only in IDLE or STOP.
- PAR_EN  in  1  parity bit enable; sampled at acceptance.
- PAR_TYP  in  1  0 = even, 1 = odd; sampled at acceptance.
- ser_done  in  1  serializer completion flag, high during its last shift cycle.
- ser_data  in  1  serializer output bit.
- ser_en  out  1  serializer shift enable.
- tx_out  out  1  UART line, idle high.
- busy  out  1  frame in progress.
- tx_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, immediate): state = IDLE, ser_en = 0, tx_out = 1, busy = 0, tx_err = 0, parity register = 0, watchdog = 0.
- States: IDLE, START, DATA, PARITY, STOP. Outputs are Moore, decoded from the state register.
- ser_en = 1 only in DATA.
- busy = 1 in START, DATA, PARITY and STOP.
- tx_out by state:
  - IDLE: 1
  - START: 0
  - DATA: ser_data
  - PARITY: par_q
  - STOP: 1
- IDLE: Data_valid at a clock edge → go to START. At the same edge, latch par_en_q = PAR_EN and par_q = ^P_Data XOR PAR_TYP.
- START: exactly 1 cycle → go to DATA. The watchdog clears on entry to DATA.
- DATA: the watchdog increments each cycle.
  - If ser_done = 1 → go to PARITY if par_en_q, else STOP.
  - If the watchdog reaches DATA_WIDTH+WDOG_SLACK-1 without ser_done → go to STOP and pulse tx_err for 1 cycle. The frame is still closed with a stop bit.
- PARITY: exactly 1 cycle → go to STOP.
- STOP: exactly 1 cycle.
  - If Data_valid = 1 → go to START (back-to-back). Latch parity exactly as in IDLE; busy stays high.
  - Otherwise → go to IDLE.
- Data_valid is ignored in START, DATA and PARITY. The upstream must not assert it while busy, except in the STOP cycle.
- Frame length from the acceptance edge:
  - with parity: 1 + DATA_WIDTH + 1 + 1 = 11 cycles for DATA_WIDTH = 8;
  - without parity: 10 cycles.
- ser_done outside DATA is ignored.
- Mid-frame reset: tx_out returns to 1 asynchronously and no partial frame is resumed.
- Unreachable state encodings → recover to IDLE.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: adds state STOP2 after STOP. STOP always goes to STOP2, and STOP2 carries the back-to-back and IDLE transition rules. tx_out = 1 and busy = 1 in STOP2; the frame is one cycle longer.
- Undefined: single stop bit, as above.

Decomposition:
- Package uart_tx_pkg holds:
  - state enum encoding (IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, STOP2 = 5);
  - tx_out select encoding (SEL_START = 0, SEL_STOP = 1, SEL_DATA = 2, SEL_PAR = 3);
  - constants PAR_EVEN = 0, PAR_ODD = 1.
- One sub-module, uart_tx_parity: combinational parity of P_Data with PAR_TYP, instantiated once. FSM, watchdog and output mux stay in uart_tx_ctrl.

Test Plan:
- Basic frame: P_Data = 0xA5, PAR_EN = 1, PAR_TYP = 0, with a serializer model → tx_out = 0,1,0,1,0,0,1,0,1,0,1. busy is high for 11 cycles. ser_en is high for exactly 8 cycles.
- Odd parity, no-parity variant: P_Data = 0x07 with PAR_TYP = 1 gives parity bit 0. A second frame with PAR_EN = 0 has no parity cycle and lasts 10 cycles.
- Back-to-back: Data_valid during STOP with 0x3C → START on the next cycle, busy never drops, 22 contiguous busy cycles.
- Watchdog: ser_done held 0 → after 10 DATA cycles the FSM enters STOP, tx_err pulses for 1 cycle, then IDLE.
- Reset mid-DATA: assert rst on the 4th DATA cycle → tx_out = 1, busy = 0, ser_en = 0 immediately. After release, a fresh 0x81 frame is correct.
- Ignored request: Data_valid pulsed during DATA → no effect on state or frame length. With UART_TX_TWO_STOP_EN defined, a frame with PAR_EN = 1 lasts 12 cycles.
